// File: rtl/rv32_issue_scoreboard_pkg.sv
// Shared types for the RV32 issue scoreboard.
//
// hazard_slot_t : one tracked post-decode pipeline slot {valid, rd, wb, is_load}
// fwd_sel_t     : forwarding source select (regfile, EX, MEM, WB)
// slot_to_fwd   : maps a slot index (0 = EX) to its forwarding select code
package rv32_types;

  localparam int RV32_REG_ADDR_W = 5;

  typedef struct packed {
    logic                       valid;
    logic [RV32_REG_ADDR_W-1:0] rd;
    logic                       wb;
    logic                       is_load;
  } hazard_slot_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  function automatic fwd_sel_t slot_to_fwd(input int idx);
    logic [1:0] code;
    code = 2'(idx + 1);
    return fwd_sel_t'(code);
  endfunction

endpackage

// File: rtl/rv32_hazard_match.sv
// Compares one decode source register against every tracked slot.
//
// Ports:
//   slots   in  tracked slots, index 0 = EX (youngest)
//   rs      in  source register index
//   use_rs  in  source is actually read by the instruction
//   match   out per-slot match vector
//   fwd_sel out forwarding select of the youngest matching slot (FWD_RF if none)
module rv32_hazard_match
  import rv32_types::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  hazard_slot_t [PIPE_DEPTH-1:0] slots,
  input  logic [RV32_REG_ADDR_W-1:0]    rs,
  input  logic                          use_rs,
  output logic [PIPE_DEPTH-1:0]         match,
  output fwd_sel_t                      fwd_sel
);

  always_comb begin
    match   = '0;
    fwd_sel = FWD_RF;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      // x0 is hard-wired zero, so it never creates a dependency.
      match[i] = slots[i].valid & slots[i].wb & (slots[i].rd != '0) &
                 (slots[i].rd == rs) & use_rs;
    end
    // Walk from oldest to youngest so the youngest match wins.
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      if (match[i]) fwd_sel = slot_to_fwd(i);
    end
  end

endmodule

// File: rtl/rv32_issue_scoreboard.sv
// Issue scoreboard between decode and execute.
//
// Tracks destination registers of in-flight instructions in a shadow pipeline
// (slot 0 = EX, 1 = MEM, 2 = WB), stalls decode on hazards or selects a
// forwarding source, and counts hazard-stall cycles (saturating).
//
// Build option: define RV32_ISSUE_BYPASS_EN to enable forwarding; only
// load-use in EX then stalls. Without it every match in any slot stalls and
// fwd_sel_* are tied to zero.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   id_valid/ready  decode handshake
//   id_rs1/rs2      source indices, id_use_rs = {rs2 used, rs1 used}
//   id_rd, id_register_wb, id_is_load  destination info of the decode instr
//   pipe_hold       downstream backpressure, freezes all slots
//   flush           taken branch in EX, kills the decode instruction
//   ex_issue        decode instruction enters EX at the next edge
//   fwd_sel_rs1/2   0 = regfile, 1 = EX, 2 = MEM, 3 = WB
//   stall_cycles    hazard-stall cycle count
//
// Handshake: decode holds id_valid with a stable instruction until it sees
// id_ready; id_ready high means the instruction leaves decode this cycle,
// either issued (ex_issue) or discarded by flush. id_ready does not depend on
// id_valid for the hold/flush terms, so decode may observe it at any time.
module rv32_issue_scoreboard
  import rv32_types::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [1:0]            id_use_rs,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_register_wb,
  input  logic                  id_is_load,
  input  logic                  pipe_hold,
  input  logic                  flush,
  output logic                  ex_issue,
  output logic [1:0]            fwd_sel_rs1,
  output logic [1:0]            fwd_sel_rs2,
  output logic [31:0]           stall_cycles
);

  hazard_slot_t [PIPE_DEPTH-1:0] slot_q, slot_d;
  logic [31:0]                   stall_cycles_q, stall_cycles_d;

  logic [PIPE_DEPTH-1:0] match_rs1, match_rs2;
  fwd_sel_t              fwd_rs1, fwd_rs2;
  logic                  hazard, stall;

  rv32_hazard_match #(.PIPE_DEPTH(PIPE_DEPTH)) u_match_rs1 (
    .slots   (slot_q),
    .rs      (id_rs1),
    .use_rs  (id_use_rs[0]),
    .match   (match_rs1),
    .fwd_sel (fwd_rs1)
  );

  rv32_hazard_match #(.PIPE_DEPTH(PIPE_DEPTH)) u_match_rs2 (
    .slots   (slot_q),
    .rs      (id_rs2),
    .use_rs  (id_use_rs[1]),
    .match   (match_rs2),
    .fwd_sel (fwd_rs2)
  );

`ifdef RV32_ISSUE_BYPASS_EN
  // A load result is only available after MEM, so a consumer right behind it
  // waits one bubble; everything else is forwarded.
  logic unused_match;
  assign unused_match = ^{match_rs1, match_rs2};
  assign hazard      = (match_rs1[0] | match_rs2[0]) & slot_q[0].is_load;
  assign fwd_sel_rs1 = fwd_rs1;
  assign fwd_sel_rs2 = fwd_rs2;
`else
  // Without bypass the consumer waits until the producer has left WB, since
  // the regfile is written on the WB edge.
  logic unused_fwd;
  assign unused_fwd  = ^{fwd_rs1, fwd_rs2};
  assign hazard      = (|match_rs1) | (|match_rs2);
  assign fwd_sel_rs1 = 2'd0;
  assign fwd_sel_rs2 = 2'd0;
`endif

  // Flush wins over stall: the killed instruction need not wait for operands.
  assign stall        = id_valid & hazard & ~flush;
  assign id_ready     = flush | (~stall & ~pipe_hold);
  assign ex_issue     = id_valid & ~flush & ~stall & ~pipe_hold;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    slot_d         = slot_q;
    stall_cycles_d = stall_cycles_q;
    if (!pipe_hold) begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[0] = '0;
      if (ex_issue) begin
        slot_d[0].valid   = 1'b1;
        slot_d[0].rd      = id_rd;
        slot_d[0].wb      = id_register_wb;
        slot_d[0].is_load = id_is_load;
      end
    end
    if (stall && !pipe_hold && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      slot_q         <= slot_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_rv32_issue_scoreboard.sv
// Self-checking bench for rv32_issue_scoreboard: directed scenarios followed
// by randomized traffic, all checked every cycle against a reference model
// that tracks issued instructions by age rather than by slot.
module tb_rv32_issue_scoreboard;

  localparam int PIPE_DEPTH = 3;
  localparam int NO_AGE     = 99;

`ifdef RV32_ISSUE_BYPASS_EN
  localparam logic [31:0] EXP_ALU_DEP_STALLS  = 32'd0;
  localparam logic [31:0] EXP_LOAD_DEP_STALLS = 32'd1;
`else
  localparam logic [31:0] EXP_ALU_DEP_STALLS  = 32'd3;
  localparam logic [31:0] EXP_LOAD_DEP_STALLS = 32'd3;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_use_rs;
  logic        id_register_wb, id_is_load;
  logic        pipe_hold, flush;
  logic        ex_issue;
  logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  rv32_issue_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH), .REG_ADDR_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs      (id_use_rs),
    .id_rd          (id_rd),
    .id_register_wb (id_register_wb),
    .id_is_load     (id_is_load),
    .pipe_hold      (pipe_hold),
    .flush          (flush),
    .ex_issue       (ex_issue),
    .fwd_sel_rs1    (fwd_sel_rs1),
    .fwd_sel_rs2    (fwd_sel_rs2),
    .stall_cycles   (stall_cycles)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [4:0] rd;
    bit         wb;
    bit         ld;
    int         age;   // completed advancing edges since issue; 0 = in EX
  } ent_t;

  ent_t        inflight[$];
  logic [31:0] m_cnt;
  bit          m_ready;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit reads(input ent_t e, input logic [4:0] rs, input bit used);
    return used && e.wb && (e.rd != 5'd0) && (e.rd == rs);
  endfunction

  // One cycle: check outputs for the current inputs, then advance the model.
  task automatic step();
    int a1, a2;
    bit hz, st, exp_issue;
    logic [1:0] f1, f2;
    #1;
    a1 = NO_AGE; a2 = NO_AGE; hz = 0;
    foreach (inflight[k]) begin
      if (reads(inflight[k], id_rs1, id_use_rs[0]) && inflight[k].age < a1) a1 = inflight[k].age;
      if (reads(inflight[k], id_rs2, id_use_rs[1]) && inflight[k].age < a2) a2 = inflight[k].age;
`ifdef RV32_ISSUE_BYPASS_EN
      if (inflight[k].age == 0 && inflight[k].ld &&
          (reads(inflight[k], id_rs1, id_use_rs[0]) || reads(inflight[k], id_rs2, id_use_rs[1])))
        hz = 1;
`endif
    end
`ifdef RV32_ISSUE_BYPASS_EN
    f1 = (a1 == NO_AGE) ? 2'd0 : 2'(a1 + 1);
    f2 = (a2 == NO_AGE) ? 2'd0 : 2'(a2 + 1);
`else
    hz = (a1 != NO_AGE) || (a2 != NO_AGE);
    f1 = 2'd0;
    f2 = 2'd0;
`endif
    st        = id_valid && hz && !flush;
    m_ready   = flush || (!st && !pipe_hold);
    exp_issue = id_valid && !flush && !st && !pipe_hold;
    check("id_ready",     {31'd0, id_ready}, {31'd0, m_ready});
    check("ex_issue",     {31'd0, ex_issue}, {31'd0, exp_issue});
    check("fwd_sel_rs1",  {30'd0, fwd_sel_rs1}, {30'd0, f1});
    check("fwd_sel_rs2",  {30'd0, fwd_sel_rs2}, {30'd0, f2});
    check("stall_cycles", stall_cycles, m_cnt);
    @(posedge clk);
    if (rst) begin
      inflight.delete();
      m_cnt = 32'd0;
    end else begin
      if (st && !pipe_hold && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (!pipe_hold) begin
        ent_t nq[$];
        foreach (inflight[k]) begin
          ent_t e;
          e = inflight[k];
          e.age++;
          if (e.age < PIPE_DEPTH) nq.push_back(e);
        end
        if (exp_issue) begin
          ent_t e;
          e.rd = id_rd; e.wb = id_register_wb; e.ld = id_is_load; e.age = 0;
          nq.push_back(e);
        end
        inflight = nq;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] use_rs,
                           input logic [4:0] rd, input bit wb, input bit ld);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs = use_rs;
    id_rd = rd; id_register_wb = wb; id_is_load = ld;
  endtask

  task automatic idle();
    id_valid = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Drain the pipe so the next scenario starts clean.
  task automatic drain();
    idle();
    repeat (PIPE_DEPTH + 1) step();
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] base;

  initial begin
    rst = 1'b1; m_cnt = 32'd0;
    idle();
    set_instr(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    id_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Reset state: empty slots, instruction issues straight through.
    set_instr(5'd3, 5'd4, 2'b11, 5'd9, 1'b1, 1'b0);
    step();
    check("reset_cnt", stall_cycles, 32'd0);
    rst = 1'b0;
    drain();

    // addi x5,x0,1 ; add x6,x5,x5
    do_reset();
    set_instr(5'd0, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0); step();
    set_instr(5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
    repeat (int'(EXP_ALU_DEP_STALLS) + 1) step();
    drain();
    check("alu_dep_stalls", stall_cycles, EXP_ALU_DEP_STALLS);

    // lw x7 ; add x8,x7,x0
    do_reset();
    set_instr(5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1); step();
    set_instr(5'd7, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0);
    repeat (int'(EXP_LOAD_DEP_STALLS) + 1) step();
    drain();
    check("load_dep_stalls", stall_cycles, EXP_LOAD_DEP_STALLS);

    // addi x0,x0,0 ; add x1,x0,x0 : x0 never matches
    do_reset();
    set_instr(5'd0, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0); step();
    set_instr(5'd0, 5'd0, 2'b11, 5'd1, 1'b1, 1'b0); step();
    drain();
    check("x0_no_stall", stall_cycles, 32'd0);

    // addi x5 ; lui x5 (no sources used)
    do_reset();
    set_instr(5'd0, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0); step();
    set_instr(5'd5, 5'd5, 2'b00, 5'd5, 1'b1, 1'b0); step();
    drain();
    check("unused_no_stall", stall_cycles, 32'd0);

    // Flush while stalled on load-use
    do_reset();
    set_instr(5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1); step();
    set_instr(5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
    flush = 1'b1; step();
    flush = 1'b0; id_valid = 1'b0; step();
    check("flush_cnt", stall_cycles, 32'd0);
    drain();

    // pipe_hold for two cycles with a dependent instruction waiting
    do_reset();
    set_instr(5'd0, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0); step();
    set_instr(5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
    pipe_hold = 1'b1; step(); step();
    check("hold_cnt", stall_cycles, 32'd0);
    pipe_hold = 1'b0;
    repeat (int'(EXP_ALU_DEP_STALLS) + 1) step();
    drain();

    // Reset mid-stall: dependency forgotten, instruction then issues
    do_reset();
    set_instr(5'd0, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1); step();
    set_instr(5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0); step();
    rst = 1'b1; step();
    rst = 1'b0;
    check("rst_mid_issue", {31'd0, ex_issue}, 32'd1);
    check("rst_mid_fwd", {30'd0, fwd_sel_rs1}, 32'd0);
    step();
    drain();

    // Randomized traffic; instruction held stable until consumed.
    do_reset();
    base = 32'd0;
    m_ready = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!id_valid || m_ready) begin
        set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        id_valid = ($urandom_range(0, 4) != 0);
      end
      pipe_hold = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
      if (rst) m_ready = 1'b1;
    end
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
